// File: rtl/ysyx_22050710_dmem_resp.sv
// rtl/ysyx_22050710_dmem_resp.sv - memory-side responder for LSU load/store requests
// Serves one byte-masked 64-bit access at a time after a fixed latency over valid/ready channels.
module ysyx_22050710_dmem_resp #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [63:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wmask,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] addr_q, wdata_q;
    logic        wen_q;
    logic [7:0]  wmask_q;
    logic [63:0] mem_q [DEPTH];

    logic        accept, do_access;
    logic [63:0] acc_addr, acc_wdata, acc_off;
    logic        acc_wen, acc_hit;
    logic [7:0]  acc_wmask;
    logic [AW-1:0] acc_idx;

    assign accept = (state_q == IDLE) && i_req_valid;

    // With LATENCY=1 the access happens on the accept edge itself, so it must use the live inputs.
    assign acc_addr  = (state_q == IDLE) ? i_req_addr  : addr_q;
    assign acc_wen   = (state_q == IDLE) ? i_req_wen   : wen_q;
    assign acc_wdata = (state_q == IDLE) ? i_req_wdata : wdata_q;
    assign acc_wmask = (state_q == IDLE) ? i_req_wmask : wmask_q;
    assign acc_off   = acc_addr - BASE;
    assign acc_hit   = (acc_addr >= BASE) && (acc_off < SPAN);
    assign acc_idx   = acc_off[AW+2:3];

    assign o_req_ready  = (state_q == IDLE);
    assign o_resp_valid = (state_q == RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = RESP;
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            rdata_d = (!acc_wen && acc_hit) ? mem_q[acc_idx] : 64'd0;
            err_d   = !acc_hit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_q  <= i_req_addr;
            wen_q   <= i_req_wen;
            wdata_q <= i_req_wdata;
            wmask_q <= i_req_wmask;
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge i_clk) begin
        if (do_access && !i_rst && acc_wen && acc_hit) begin
            for (int k = 0; k < 8; k++) begin
                if (acc_wmask[k]) begin
                    mem_q[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_dmem_resp.sv
// tb/tb_ysyx_22050710_dmem_resp.sv - directed bench for ysyx_22050710_dmem_resp
// Instances 0/1/2 run with LATENCY 2/1/7 against hand-computed expectations.
module tb_ysyx_22050710_dmem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [63:0] req_addr   [3];
    logic        req_wen    [3];
    logic [63:0] req_wdata  [3];
    logic [7:0]  req_wmask  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [63:0] resp_rdata [3];
    logic        resp_err   [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_22050710_dmem_resp #(
            .DEPTH  (1024),
            .BASE   (64'h0000_0000_8000_0000),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 7))
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wen   (req_wen[g]),
            .i_req_wdata (req_wdata[g]),
            .i_req_wmask (req_wmask[g]),
            .o_resp_valid(resp_valid[g]),
            .i_resp_ready(resp_ready[g]),
            .o_resp_rdata(resp_rdata[g]),
            .o_resp_err  (resp_err[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the accept edge; returns cycles until resp_valid is seen.
    task automatic wait_resp(input int g, output int lat, output logic [63:0] rd, output logic er);
        int cycles = 1;
        while (!resp_valid[g] && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        lat = cycles;
        rd  = resp_rdata[g];
        er  = resp_err[g];
    endtask

    task automatic handshake(input int g);
        resp_ready[g] = 1'b1;
        @(posedge clk); #1;
        resp_ready[g] = 1'b0;
        check("hs_valid_drop", 64'(resp_valid[g]), 64'd0);
        check("hs_req_ready", 64'(req_ready[g]), 64'd1);
    endtask

    task automatic do_req(input int g, input logic [63:0] addr, input logic wen,
                          input logic [63:0] wdata, input logic [7:0] wmask, input int hold,
                          output int lat, output logic [63:0] rd, output logic er);
        @(posedge clk); #1;
        req_valid[g] = 1'b1;
        req_addr[g]  = addr;
        req_wen[g]   = wen;
        req_wdata[g] = wdata;
        req_wmask[g] = wmask;
        @(posedge clk); #1;
        // Scramble request inputs after the accept edge; the DUT must ignore them.
        req_valid[g] = 1'b0;
        req_addr[g]  = ~addr;
        req_wen[g]   = ~wen;
        req_wdata[g] = ~wdata;
        req_wmask[g] = ~wmask;
        wait_resp(g, lat, rd, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(resp_valid[g]), 64'd1);
            check("bp_rdata", resp_rdata[g], rd);
            check("bp_err", 64'(resp_err[g]), 64'(er));
            check("bp_req_ready", 64'(req_ready[g]), 64'd0);
        end
        handshake(g);
    endtask

    int          lat;
    logic [63:0] rd;
    logic        er;
    int          saw_ready;

    initial begin
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 0; req_addr[g] = 0; req_wen[g] = 0;
            req_wdata[g] = 0; req_wmask[g] = 0; resp_ready[g] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready[0]), 64'd1);
        check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("rst_rdata", resp_rdata[0], 64'd0);
        check("rst_err", 64'(resp_err[0]), 64'd0);

        // Full write then read-after-write
        do_req(0, 64'h8000_0010, 1, 64'h1122_3344_5566_7788, 8'hFF, 0, lat, rd, er);
        check("wr_latency", 64'(lat), 64'd2);
        check("wr_rdata", rd, 64'd0);
        check("wr_err", 64'(er), 64'd0);
        do_req(0, 64'h8000_0010, 0, 64'h0, 8'h00, 0, lat, rd, er);
        check("rd_latency", 64'(lat), 64'd2);
        check("rd_rdata", rd, 64'h1122_3344_5566_7788);

        // Partial mask and no-op mask
        do_req(0, 64'h8000_0020, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, lat, rd, er);
        do_req(0, 64'h8000_0020, 1, 64'h0000_0000_AB00_0000, 8'h08, 0, lat, rd, er);
        check("pm_wr_err", 64'(er), 64'd0);
        do_req(0, 64'h8000_0020, 0, 64'h0, 8'hFF, 0, lat, rd, er);
        check("pm_rdata", rd, 64'hFFFF_FFFF_ABFF_FFFF);
        do_req(0, 64'h8000_0020, 1, 64'h0, 8'h00, 0, lat, rd, er);
        check("nop_latency", 64'(lat), 64'd2);
        do_req(0, 64'h8000_0020, 0, 64'h0, 8'h00, 0, lat, rd, er);
        check("nop_rdata", rd, 64'hFFFF_FFFF_ABFF_FFFF);

        // Back-pressure on a read response
        do_req(0, 64'h8000_0010, 0, 64'h0, 8'h00, 5, lat, rd, er);
        check("bp_rdata_val", rd, 64'h1122_3344_5566_7788);

        // Out of range accesses leave the edge words intact
        do_req(0, 64'h8000_0000, 1, 64'h0101_0101_0101_0101, 8'hFF, 0, lat, rd, er);
        do_req(0, 64'h8000_1FF8, 1, 64'h0202_0202_0202_0202, 8'hFF, 0, lat, rd, er);
        do_req(0, 64'h7FFF_FFF8, 0, 64'h0, 8'hFF, 0, lat, rd, er);
        check("oor_rd_err", 64'(er), 64'd1);
        check("oor_rd_rdata", rd, 64'd0);
        do_req(0, 64'h8000_2000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, lat, rd, er);
        check("oor_wr_err", 64'(er), 64'd1);
        check("oor_wr_rdata", rd, 64'd0);
        do_req(0, 64'h8000_0000, 0, 64'h0, 8'h00, 0, lat, rd, er);
        check("oor_first_word", rd, 64'h0101_0101_0101_0101);
        check("oor_ok_err", 64'(er), 64'd0);
        do_req(0, 64'h8000_1FF8, 0, 64'h0, 8'h00, 0, lat, rd, er);
        check("oor_last_word", rd, 64'h0202_0202_0202_0202);

        // Reset while a write is in BUSY
        do_req(0, 64'h8000_0030, 1, 64'h0, 8'hFF, 0, lat, rd, er);
        @(posedge clk); #1;
        req_valid[0] = 1; req_addr[0] = 64'h8000_0030; req_wen[0] = 1;
        req_wdata[0] = 64'hDEAD; req_wmask[0] = 8'hFF;
        @(posedge clk); #1;
        req_valid[0] = 0;
        check("mid_busy_ready", 64'(req_ready[0]), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 64'(resp_valid[0]), 64'd0);
        check("mid_rst_ready", 64'(req_ready[0]), 64'd1);
        check("mid_rst_rdata", resp_rdata[0], 64'd0);
        do_req(0, 64'h8000_0030, 0, 64'h0, 8'h00, 0, lat, rd, er);
        check("mid_rst_readback", rd, 64'd0);

        // LATENCY=1 instance
        do_req(1, 64'h8000_0040, 1, 64'hCAFE_F00D_1234_5678, 8'hF0, 0, lat, rd, er);
        check("l1_wr_latency", 64'(lat), 64'd1);
        do_req(1, 64'h8000_0040, 0, 64'h0, 8'h00, 0, lat, rd, er);
        check("l1_rd_latency", 64'(lat), 64'd1);
        check("l1_rdata_hi", rd[63:32], 64'hCAFE_F00D);

        // LATENCY=7 with a request held pending while busy
        do_req(2, 64'h8000_0050, 1, 64'h0, 8'hFF, 0, lat, rd, er);
        @(posedge clk); #1;
        req_valid[2] = 1; req_addr[2] = 64'h8000_0050; req_wen[2] = 1;
        req_wdata[2] = 64'h5A5A_0000_0000_A5A5; req_wmask[2] = 8'hFF;
        @(posedge clk); #1;
        req_wen[2] = 0; req_wdata[2] = 64'h0;
        saw_ready = 0;
        begin
            int cycles = 1;
            while (!resp_valid[2] && cycles < 40) begin
                if (req_ready[2]) saw_ready = 1;
                @(posedge clk); #1;
                cycles++;
            end
            lat = cycles;
        end
        check("l7_latency", 64'(lat), 64'd7);
        check("l7_no_accept", 64'(saw_ready), 64'd0);
        handshake(2);
        @(posedge clk); #1;
        req_valid[2] = 0;
        wait_resp(2, lat, rd, er);
        check("l7_pend_latency", 64'(lat), 64'd7);
        check("l7_pend_rdata", rd, 64'h5A5A_0000_0000_A5A5);
        handshake(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22050710_dmem_resp.md
Name: ysyx_22050710_dmem_resp

Overview:
Data-memory responder: the memory-side end of the LSU load/store interface, serving the LSU core instead of DPI pmem calls. Accepts one request at a time over a valid/ready request channel. Performs a byte-masked 64-bit write or an aligned 64-bit read on internal storage after a fixed, programmable latency. Returns the result on a valid/ready response channel.

Parameters:
DEPTH, 1024, number of 64-bit words of storage; power of two.
BASE, 64'h0000_0000_8000_0000, byte address of word 0.
LATENCY, 2, cycles from the request-accept edge to o_resp_valid high; legal range 1..15.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_req_valid  input  1  request present
o_req_ready  output  1  responder can accept a request
i_req_addr  input  64  byte address; bits [2:0] ignored (word aligned)
i_req_wen  input  1  1 = write, 0 = read
i_req_wdata  input  64  write data, already lane-aligned by the requester
i_req_wmask  input  8  byte enables; bit k enables wdata[8k+7:8k]
o_resp_valid  output  1  response present
i_resp_ready  input  1  requester accepts the response
o_resp_rdata  output  64  read data: the full aligned word; 0 for writes and errors
o_resp_err  output  1  address out of range

Behaviour:
- Reset: state IDLE, any pending request dropped. o_resp_valid=0, o_resp_rdata=0, o_resp_err=0, latency counter=0.
- Storage contents are not cleared by reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - o_req_ready=1, combinational from state; it is 1 in the first cycle after reset deasserts.
  - On i_req_valid & o_req_ready, capture addr/wen/wdata/wmask, load the counter, and go to BUSY.
  - If LATENCY=1, go directly to RESP instead.
- BUSY:
  - o_req_ready=0.
  - The counter decrements each cycle.
  - On the final count, perform the access and enter RESP, so that o_resp_valid rises exactly LATENCY cycles after the accept edge.
- Access, on the edge entering RESP:
  - Word index = (addr - BASE) >> 3.
  - In range means BASE <= addr < BASE + DEPTH*8.
  - Write: each byte k with wmask[k]=1 is updated from wdata; other bytes are unchanged. o_resp_rdata=0.
  - wmask=0 is a legal no-op write that still responds.
  - Read: o_resp_rdata = stored word. wmask is ignored. No shifting or sign extension; the requester does that.
  - Out of range: no storage change, o_resp_rdata=0, o_resp_err=1.
- RESP:
  - o_resp_valid=1; o_resp_rdata and o_resp_err are held stable until the handshake.
  - On i_resp_ready, the next state is IDLE, o_resp_valid=0 and data/err return to 0.
  - No new request is accepted in the handshake cycle; back-to-back throughput is one request per LATENCY+2 cycles minimum.
- Read-after-write: a read accepted after a write's response returns the written data.
- Request inputs are sampled only on the accept edge; later changes are ignored.
- Reset mid-operation: reset in BUSY or RESP aborts. A write still in BUSY is not performed; a write already in RESP is already committed. The next cycle is IDLE with all outputs at reset values.
- The handshake is AXI-like: valid is never withdrawn by the responder before ready.

Test Plan:
- Write then read, LATENCY=2: write addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF, i_resp_ready=1 → resp_valid exactly 2 cycles after accept, rdata=0, err=0. Then read the same addr → rdata=0x1122334455667788.
- Partial mask: word preloaded with 0xFFFF_FFFF_FFFF_FFFF; write wdata 0x0000_0000_AB00_0000, wmask 0x08 → a later read returns 0xFFFF_FFFF_ABFF_FFFF.
- Back-pressure: hold i_resp_ready=0 for 5 cycles after resp_valid → valid, rdata and err stay stable and o_req_ready=0 throughout. Asserting ready → valid drops next cycle and o_req_ready=1.
- Out of range: read 0x7FFF_FFF8 and write BASE+DEPTH*8 → err=1, rdata=0, and neighbouring words are unchanged on readback.
- Reset mid-operation: accept write 0xDEAD to a word holding 0, assert i_rst in BUSY → the next cycle is IDLE with resp_valid=0. A readback returns 0.
- Latency sweep: LATENCY=1 and 7 → resp_valid rises 1 and 7 cycles after the accept edge. Requests presented while not ready are not accepted until IDLE.
